// File: rtl/mod_exp_seq.sv
// Sequential left-to-right square-and-multiply modular exponentiation
// over a single shared combinational Montgomery multiplier.

module mont_mul #(
   parameter int LEN = 2048
) (
   input  logic [LEN-1:0] a,
   input  logic [LEN-1:0] b,
   input  logic [LEN-1:0] n,
   input  logic [LEN-1:0] n_prime,
   output logic [LEN-1:0] p
);
   logic [2*LEN-1:0] t;
   logic [LEN-1:0]   m;
   logic [2*LEN-1:0] mn;
   logic             c;
   logic [LEN:0]     u;
   logic [LEN:0]     d;

   assign t  = {{LEN{1'b0}}, a} * {{LEN{1'b0}}, b};
   assign m  = t[LEN-1:0] * n_prime;
   assign mn = {{LEN{1'b0}}, m} * {{LEN{1'b0}}, n};
   // Low halves of t and m*n sum to 0 or exactly R, so the carry is
   // set whenever either low half is nonzero.
   assign c  = |(t[LEN-1:0] | mn[LEN-1:0]);
   assign u  = {1'b0, t[2*LEN-1:LEN]} + {1'b0, mn[2*LEN-1:LEN]}
             + {{LEN{1'b0}}, c};
   assign d  = u - {1'b0, n};
   assign p  = d[LEN] ? u[LEN-1:0] : d[LEN-1:0];
endmodule

module mod_exp_seq #(
   parameter int LEN     = 2048,
   parameter int EXP_LEN = LEN
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic               ready,
   output logic               busy,
   input  logic [LEN-1:0]     base,
   input  logic [EXP_LEN-1:0] exp,
   input  logic [LEN-1:0]     n,
   input  logic [LEN-1:0]     n_prime,
   input  logic [LEN-1:0]     r2_mod_n,
   output logic [LEN-1:0]     res,
   output logic               done
);
   localparam int IW = (EXP_LEN > 1) ? $clog2(EXP_LEN) : 1;
   localparam logic [LEN-1:0] ONE = LEN'(1);

   typedef enum logic [2:0] {
      IDLE, CONV_B, CONV_1, SQR, MUL, CONV_OUT, DONE
   } state_t;

   state_t state, state_nx;

   logic [LEN-1:0]     base_q, n_q, np_q, r2_q;
   logic [LEN-1:0]     base_m, acc;
   logic [EXP_LEN-1:0] exp_q;
   logic [IW-1:0]      idx;
   logic [LEN-1:0]     op_a, op_b, prod;
   logic               accept;
   logic               last;

   assign accept = start & ready;
   assign last   = (idx == '0);

   mont_mul #(.LEN(LEN)) u_mm (
      .a       (op_a),
      .b       (op_b),
      .n       (n_q),
      .n_prime (np_q),
      .p       (prod)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE, DONE: state_nx = start ? CONV_B : IDLE;
         CONV_B:     state_nx = CONV_1;
         CONV_1:     state_nx = SQR;
         SQR: begin
            if (exp_q[idx]) state_nx = MUL;
            else if (last)  state_nx = CONV_OUT;
            else            state_nx = SQR;
         end
         MUL:        state_nx = last ? CONV_OUT : SQR;
         CONV_OUT:   state_nx = DONE;
         default:    state_nx = IDLE;
      endcase
   end

   always_comb begin
      ready = (state == IDLE) || (state == DONE);
      busy  = ~ready;
      done  = (state == DONE);
      op_a  = acc;
      op_b  = acc;
      unique case (state)
         CONV_B:   begin op_a = base_q; op_b = r2_q;   end
         CONV_1:   begin op_a = ONE;    op_b = r2_q;   end
         MUL:      begin op_a = acc;    op_b = base_m; end
         CONV_OUT: begin op_a = acc;    op_b = ONE;    end
         default:  begin op_a = acc;    op_b = acc;    end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q <= '0;
         n_q    <= '0;
         np_q   <= '0;
         r2_q   <= '0;
         exp_q  <= '0;
         idx    <= '0;
         base_m <= '0;
         acc    <= '0;
         res    <= '0;
      end else begin
         if (accept) begin
            base_q <= base;
            n_q    <= n;
            np_q   <= n_prime;
            r2_q   <= r2_mod_n;
            exp_q  <= exp;
            idx    <= IW'(EXP_LEN - 1);
         end
         // idx steps down after the multiply when the bit is set.
         case (state)
            CONV_B: base_m <= prod;
            CONV_1: acc    <= prod;
            SQR: begin
               acc <= prod;
               if (!exp_q[idx] && !last) idx <= idx - IW'(1);
            end
            MUL: begin
               acc <= prod;
               if (!last) idx <= idx - IW'(1);
            end
            CONV_OUT: res <= prod;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mod_exp_seq.sv
// Directed and randomized bench for mod_exp_seq at LEN=8, n=13.

module tb_mod_exp_seq;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       ready, busy, done;
   logic [7:0] base = '0;
   logic [7:0] exp = '0;
   logic [7:0] n = 8'd13;
   logic [7:0] n_prime = 8'd59;
   logic [7:0] r2_mod_n = 8'd3;
   logic [7:0] res;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] b;
      logic [7:0] e;
      logic [7:0] r;
      int         bl;
   } vec_t;

   vec_t vecs[10];

   always #5 clk = ~clk;

   mod_exp_seq #(.LEN(8), .EXP_LEN(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .ready    (ready),
      .busy     (busy),
      .base     (base),
      .exp      (exp),
      .n        (n),
      .n_prime  (n_prime),
      .r2_mod_n (r2_mod_n),
      .res      (res),
      .done     (done)
   );

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, req);
      end
   endtask

   function automatic int modpow(input int b, input int e, input int m);
      int r = 1;
      int x = b % m;
      for (int i = 0; i < 8; i++) begin
         if (e[i]) r = (r * x) % m;
         x = (x * x) % m;
      end
      return r;
   endfunction

   task automatic do_op(input logic [7:0] b, input logic [7:0] e,
                        input int poke_at, output logic [7:0] r,
                        output int bc, output int dk);
      @(negedge clk);
      base  = b;
      exp   = e;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      base  = 8'd9;
      exp   = ~e;
      bc = 0;
      dk = 0;
      r  = '0;
      for (int k = 1; k <= 100; k++) begin
         if (k > 1) begin
            @(posedge clk);
            #1;
         end
         start = (k == poke_at);
         if (busy) bc++;
         if (done) begin
            dk = k;
            r  = res;
            chk("ready_at_done", int'(ready), 1);
            break;
         end
      end
      start = 1'b0;
   endtask

   initial begin
      logic [7:0] r;
      int bc, dk, dones, gap_busy;
      logic [7:0] rb, re;

      vecs[0] = '{8'd2,  8'd5,   8'd6,  13};
      vecs[1] = '{8'd3,  8'd12,  8'd1,  13};
      vecs[2] = '{8'd7,  8'd0,   8'd1,  11};
      vecs[3] = '{8'd0,  8'd5,   8'd0,  13};
      vecs[4] = '{8'd12, 8'd255, 8'd12, 19};
      vecs[5] = '{8'd1,  8'd255, 8'd1,  19};
      vecs[6] = '{8'd5,  8'd1,   8'd5,  12};
      vecs[7] = '{8'd4,  8'd2,   8'd3,  12};
      vecs[8] = '{8'd6,  8'd3,   8'd8,  13};
      vecs[9] = '{8'd11, 8'd128, 8'd9,  12};

      #12;
      chk("rst_ready", int'(ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_res", int'(res), 0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         do_op(vecs[i].b, vecs[i].e, -1, r, bc, dk);
         chk($sformatf("vec%0d_res", i), int'(r), int'(vecs[i].r));
         chk($sformatf("vec%0d_busy", i), bc, vecs[i].bl);
         chk($sformatf("vec%0d_donecyc", i), dk, vecs[i].bl + 1);
      end

      // start held high across two operations
      @(negedge clk);
      base  = 8'd2;
      exp   = 8'd5;
      start = 1'b1;
      @(posedge clk);
      #1;
      base  = 8'd12;
      exp   = 8'd255;
      dones = 0;
      gap_busy = 0;
      for (int k = 1; k <= 100; k++) begin
         if (k > 1) begin
            @(posedge clk);
            #1;
         end
         if (k == 15) gap_busy = int'(busy);
         if (done) begin
            dones++;
            if (dones == 1) begin
               chk("b2b_res1", int'(res), 6);
               chk("b2b_done1_cyc", k, 14);
            end else begin
               chk("b2b_res2", int'(res), 12);
               chk("b2b_done2_cyc", k, 34);
               start = 1'b0;
               break;
            end
         end
      end
      start = 1'b0;
      chk("b2b_dones", dones, 2);
      chk("b2b_no_gap", gap_busy, 1);
      @(posedge clk);
      #1;
      chk("b2b_idle_after", int'(ready), 1);
      chk("b2b_no_third_done", int'(done), 0);

      // start pulsed while busy is ignored
      do_op(8'd3, 8'd12, 4, r, bc, dk);
      chk("poke_res", int'(r), 1);
      chk("poke_busy", bc, 13);

      // asynchronous reset mid-operation
      @(negedge clk);
      base  = 8'd2;
      exp   = 8'd5;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      chk("pre_rst_busy", int'(busy), 1);
      chk("pre_rst_res", int'(res), 1);
      rst_n = 1'b0;
      #1;
      chk("arst_ready", int'(ready), 1);
      chk("arst_busy", int'(busy), 0);
      chk("arst_res", int'(res), 0);
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (done) dones++;
      end
      chk("arst_no_done", dones, 0);
      do_op(8'd2, 8'd5, -1, r, bc, dk);
      chk("post_rst_res", int'(r), 6);
      chk("post_rst_busy", bc, 13);

      for (int i = 0; i < 1000; i++) begin
         rb = 8'($urandom_range(0, 12));
         re = 8'($urandom_range(0, 255));
         do_op(rb, re, -1, r, bc, dk);
         chk($sformatf("rnd%0d_res b=%0d e=%0d", i, rb, re),
             int'(r), modpow(int'(rb), int'(re), 13));
         chk($sformatf("rnd%0d_busy", i), bc, 11 + $countones(re));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mod_exp_seq.md
# mod_exp_seq

Sequential modular-exponentiation engine computing `res = base^exp mod n` by left-to-right square-and-multiply in the Montgomery domain. It owns exactly one combinational `mont_mul` instance and time-multiplexes its operands, one Montgomery product per clock. It uses this shared multiplier in place of the fully unrolled multiply chain. It is the scheduler the DSA signing/verification datapath uses for `g^k mod p` and `y^u2 mod p` style operations.

## Interface

Parameters:
- `LEN`, 2048: modulus/operand width in bits; also the `mont_mul` width.
- `EXP_LEN`, `LEN`: exponent width in bits; counter width is `$clog2(EXP_LEN)`.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: request; accepted only in a cycle where `ready`=1.
- `ready` out 1: engine idle, can accept `start`.
- `busy` out 1: operation in progress (`busy` = ~`ready`).
- `base` in LEN: base; caller guarantees `base` < `n`.
- `exp` in EXP_LEN: exponent.
- `n` in LEN: odd modulus, n > 1.
- `n_prime` in LEN: −n⁻¹ mod 2^LEN.
- `r2_mod_n` in LEN: R² mod n, R = 2^LEN.
- `res` out LEN: result, valid and held from the `done` cycle until the next accepted `start`.
- `done` out 1: one-cycle pulse, result ready.

## Operation

- Inputs are sampled into internal registers on the accepting edge (`start`&`ready`) and then ignored until `ready` returns. The caller may change them after acceptance.
- Registers: `base_m` (LEN), `acc` (LEN), `exp_q` (EXP_LEN), `idx` (bit counter), `res` (LEN), `state`.
- Shared `mont_mul(a,b)` = a·b·R⁻¹ mod n. Operand mux by state:
  - CONV_B: (base_q, r2) → `base_m`.
  - CONV_1: (1, r2) → `acc` (= R mod n).
  - SQR: (acc, acc) → `acc`.
  - MUL: (acc, base_m) → `acc`.
  - CONV_OUT: (acc, 1) → `res`.
- FSM:
  - IDLE -(start)-> CONV_B → CONV_1 → SQR, with `idx` = EXP_LEN−1.
  - SQR → MUL if `exp_q[idx]`=1.
  - SQR → CONV_OUT if `exp_q[idx]`=0 and `idx`=0.
  - SQR → SQR otherwise, with `idx`−1.
  - MUL → CONV_OUT if `idx`=0, else SQR with `idx`−1.
  - CONV_OUT → DONE → IDLE.
- All EXP_LEN bits are scanned (no leading-zero skip), so latency is exponent-dependent only through popcount.
- `exp`=0: result is 1.
- `base`=0 and `exp`≠0: result is 0.
- `start` while busy: ignored, not queued.
- `start` in the DONE cycle: accepted (`ready`=1 in DONE). The engine goes straight to CONV_B; `done` does not repeat.
- `start` held high continuously: back-to-back operations.
- `rst_n` low at any time, including mid-operation: asynchronous return to IDLE. The in-flight operation is discarded; no `done` is produced.

## Timing

- Reset values:
  - `state`=IDLE.
  - `ready`=1, `busy`=0, `done`=0.
  - `res`=0, all internal registers 0.
- Accepting edge T. States occupy one cycle each:
  - CONV_B in T+1.
  - CONV_1 in T+2.
  - EXP_LEN SQR cycles and popcount(exp) MUL cycles.
  - CONV_OUT.
  - DONE.
- `busy`=1 for exactly 3 + EXP_LEN + popcount(exp) cycles, covering CONV_B through CONV_OUT.
- `done`=1 and `ready`=1 in the cycle immediately after: T + 4 + EXP_LEN + popcount(exp). `res` is updated on the edge entering DONE.
- Critical path: one full `mont_mul`. No multicycle constraints are assumed by this block.

## Test plan

Config: LEN=8, EXP_LEN=8, n=13, n_prime=59, r2_mod_n=3.

- base=2, exp=5 → `res`=6; `busy` high 13 cycles; `done` pulse at T+14.
- base=3, exp=12 → `res`=1 (Fermat); `busy` 13 cycles.
- base=7, exp=0 → `res`=1; `busy` 11 cycles. Then base=0, exp=5 → `res`=0.
- `start` held high across two operations (2^5, then 12^255): `res`=6, then `res`=12 (12 ≡ −1, odd power). No idle cycle between operations; exactly one `done` per operation.
- `start` pulsed mid-operation → ignored, result unchanged. Then `rst_n` pulsed low asynchronously at cycle T+6 → `ready`=1, `res`=0 immediately, no `done`. A new operation afterwards is correct.
- Random base < n and random exp at LEN=8 → compare against a reference model for 1000 operations. Check `busy` length = 11 + popcount(exp) on every operation.
